led_frame_driver: RTL and testbench
===================================

LED_FRAME_DRIVER -- requirements
Module: led_frame_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 144, meaning pixels per frame (>=1).
REQ-002 SHALL have parameter CLK_HZ, default 24000000, meaning clk frequency.
REQ-003 SHALL have parameters T0H_NS=400, T1H_NS=800, TBIT_NS=1250, TRST_US=80, meaning 0-high, 1-high, bit period and latch low time.
REQ-004 SHALL have parameter ORDER, default GRB, meaning memory word layout (GRB or RGB).
REQ-005 SHALL have ports, one clock domain, in this order:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request pulse.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- pix_rd  out  1  pixel read strobe.
- pix_addr  out  clog2(NUM_LEDS) (min 1)  pixel index.
- pix_data  in  24  pixel word, valid the cycle after pix_rd.
- to_light  out  1  serial LED data line.

Function
REQ-006 SHALL derive cycle counts as round(CLK_HZ*T/1e9): 24 MHz gives T0H=10, T1H=19, TBIT=30; latch = CLK_HZ/1e6*TRST_US = 1920.
REQ-007 SHALL fail elaboration if NUM_LEDS<1, T0H<1, or T1H>=TBIT.
REQ-008 SHALL use states IDLE, FETCH, LOAD, SEND, LATCH; busy = (state != IDLE).
REQ-009 SHALL accept start only in IDLE, including the done cycle; ignore start otherwise.
REQ-010 SHALL, after start sampled at edge k: FETCH in cycle k+1 with pix_rd=1, pix_addr=0; LOAD in k+2 capturing pix_data; to_light rising in k+3.
REQ-011 SHALL send each bit as to_light high for T1H (bit=1) or T0H (bit=0) cycles, then low to complete TBIT cycles.
REQ-012 SHALL transmit G,R,B, MSB first; ORDER=RGB remaps pix_data[23:16]=R,[15:8]=G,[7:0]=B to wire order G,R,B.
REQ-013 SHALL prefetch pixel i+1 with pix_rd in the first cycle of bit 23 of pixel i (when i+1<NUM_LEDS), capturing into a next-pixel buffer the following cycle.
REQ-014 SHALL send bits back-to-back with zero idle cycles, including across pixel boundaries; frame length = NUM_LEDS*24*TBIT cycles.
REQ-015 SHALL, after the last bit, enter LATCH with to_light low for exactly latch cycles, then go to IDLE.
REQ-016 SHALL pulse done for exactly the first IDLE cycle after LATCH.
REQ-017 SHALL assert pix_rd exactly NUM_LEDS times per frame, addresses 0..NUM_LEDS-1 ascending; no read when NUM_LEDS=1 beyond address 0.
REQ-018 SHALL hold pix_addr at its last value when pix_rd is low.

Reset
REQ-019 SHALL, when reset is high at a clk edge, enter IDLE: busy=0, done=0, pix_rd=0, pix_addr=0, to_light=0, all counters and buffers cleared.
REQ-020 SHALL abort a frame on mid-frame reset, with to_light low from the next cycle and no done pulse.
REQ-021 SHALL give reset priority over a simultaneous start.

Configuration
REQ-022 SHALL, with macro LED_BRIGHTNESS_EN defined, add input brightness[7:0], sampled at start and held for the frame, each channel sent as (c*(brightness+1))>>8.
REQ-023 SHALL, without LED_BRIGHTNESS_EN, omit the brightness port and send channels unchanged.

Structure
REQ-024 SHALL place the state enum, ORDER enum, default timing constants and the ns-to-cycles function in shared package led_pkg.
REQ-025 SHALL implement per-bit high/low timing in sub-module led_bit_encoder, with inputs bit value and go, and outputs line and bit_end.

Verification
REQ-026 SHALL cover: NUM_LEDS=3, memory {0xFF0000,0x00FF00,0x0000AA}, start -> bit highs of 19/10 cycles matching 0xFF0000 (MSB first), 2160 SEND cycles, 1920 latch cycles, then done.
REQ-027 SHALL cover: ORDER=RGB, word 0x123456 -> wire byte sequence 0x34,0x12,0x56.
REQ-028 SHALL cover: start held high throughout a frame -> only one frame until done; the next frame starts the cycle after the done cycle.
REQ-029 SHALL cover: reset at bit 30 of pixel 1 -> to_light low next cycle, busy=0, no done, no further pix_rd.
REQ-030 SHALL cover: with LED_BRIGHTNESS_EN, brightness=127, pixel 0xFF8001 -> sent 0x7F,0x40,0x00; brightness=255 -> unchanged.
REQ-031 SHALL cover: NUM_LEDS=1 -> exactly one pix_rd, and the frame ends after 720 SEND cycles.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared states, colour order, default timing and time-to-cycle helpers
package led_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} led_state_e;
  typedef enum logic {GRB, RGB} led_order_e;

  localparam int DEF_CLK_HZ  = 24_000_000;
  localparam int DEF_T0H_NS  = 400;
  localparam int DEF_T1H_NS  = 800;
  localparam int DEF_TBIT_NS = 1250;
  localparam int DEF_TRST_US = 80;

  // Rounded to the nearest whole clock cycle.
  function automatic int ns_to_cycles(input longint clk_hz, input longint t_ns);
    return int'((clk_hz * t_ns + 64'sd500_000_000) / 64'sd1_000_000_000);
  endfunction

  function automatic int us_to_cycles(input longint clk_hz, input longint t_us);
    return int'((clk_hz * t_us) / 64'sd1_000_000);
  endfunction

  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, b} + 17'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// rtl/led_bit_encoder.sv - one-bit pulse shaper: high for T1H/T0H cycles, low to fill TBIT
module led_bit_encoder #(
  parameter int T0H  = 10,
  parameter int T1H  = 19,
  parameter int TBIT = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_val,
  input  logic go,
  output logic line,
  output logic bit_end
);

  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] high_len;
  logic          active;

  // Asserted during the last cycle of the bit so the next go lands with zero gap.
  assign bit_end = active && (cnt == CW'(TBIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      high_len <= '0;
      active   <= 1'b0;
      line     <= 1'b0;
    end else if (go) begin
      cnt      <= '0;
      high_len <= bit_val ? CW'(T1H) : CW'(T0H);
      active   <= 1'b1;
      line     <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        cnt    <= '0;
        active <= 1'b0;
        line   <= 1'b0;
      end else begin
        cnt  <= cnt + CW'(1);
        line <= (cnt + CW'(1)) < high_len;
      end
    end
  end

endmodule

// File: rtl/led_frame_driver.sv
// rtl/led_frame_driver.sv - serial LED frame driver; LED_BRIGHTNESS_EN adds a brightness input
module led_frame_driver
  import led_pkg::*;
#(
  parameter int         NUM_LEDS = 144,
  parameter int         CLK_HZ   = DEF_CLK_HZ,
  parameter int         T0H_NS   = DEF_T0H_NS,
  parameter int         T1H_NS   = DEF_T1H_NS,
  parameter int         TBIT_NS  = DEF_TBIT_NS,
  parameter int         TRST_US  = DEF_TRST_US,
  parameter led_order_e ORDER    = GRB,
  localparam int        AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [23:0]   pix_data,
  output logic          to_light
`ifdef LED_BRIGHTNESS_EN
  ,
  input  logic [7:0]    brightness
`endif
);

  localparam int T0H       = ns_to_cycles(CLK_HZ, T0H_NS);
  localparam int T1H       = ns_to_cycles(CLK_HZ, T1H_NS);
  localparam int TBIT      = ns_to_cycles(CLK_HZ, TBIT_NS);
  localparam int LATCH_CYC = us_to_cycles(CLK_HZ, TRST_US);
  localparam int LCW       = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  if (NUM_LEDS < 1 || T0H < 1 || T1H >= TBIT) begin : g_param_check
    $error("led_frame_driver: illegal NUM_LEDS or bit timing");
  end

  led_state_e     state;
  logic [AW-1:0]  pix_idx;
  logic [23:0]    cur;
  logic [23:0]    nxt;
  logic [4:0]     bit_cnt;
  logic           rd_pend;
  logic [LCW-1:0] lcnt;
  logic [23:0]    pix_wire;
  logic [23:0]    next_word;
  logic           more;
  logic           enc_go;
  logic           enc_bit;
  logic           bit_end;
`ifdef LED_BRIGHTNESS_EN
  logic [7:0]     bright_q;
`endif

  assign busy = (state != IDLE);
  assign more = (32'(pix_idx) + 32'd1) < 32'(NUM_LEDS);
  // A prefetch that landed this very cycle has not reached nxt yet.
  assign next_word = rd_pend ? pix_wire : nxt;

  always_comb begin
    pix_wire = (ORDER == RGB) ? {pix_data[15:8], pix_data[23:16], pix_data[7:0]} : pix_data;
`ifdef LED_BRIGHTNESS_EN
    pix_wire = {scale_channel(pix_wire[23:16], bright_q),
                scale_channel(pix_wire[15:8],  bright_q),
                scale_channel(pix_wire[7:0],   bright_q)};
`endif
  end

  always_comb begin
    enc_go  = 1'b0;
    enc_bit = 1'b0;
    if (state == LOAD) begin
      enc_go  = 1'b1;
      enc_bit = pix_wire[23];
    end else if (state == SEND && bit_end) begin
      if (bit_cnt != 5'd23) begin
        enc_go  = 1'b1;
        enc_bit = cur[23];
      end else if (more) begin
        enc_go  = 1'b1;
        enc_bit = next_word[23];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      pix_rd   <= 1'b0;
      pix_addr <= '0;
      pix_idx  <= '0;
      cur      <= '0;
      nxt      <= '0;
      bit_cnt  <= '0;
      rd_pend  <= 1'b0;
      lcnt     <= '0;
`ifdef LED_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      done    <= 1'b0;
      pix_rd  <= 1'b0;
      rd_pend <= pix_rd && (state == SEND);
      if (rd_pend) nxt <= pix_wire;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
            pix_idx  <= '0;
`ifdef LED_BRIGHTNESS_EN
            bright_q <= brightness;
`endif
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state   <= SEND;
          cur     <= pix_wire << 1;
          bit_cnt <= '0;
        end
        SEND: begin
          if (bit_end) begin
            if (bit_cnt != 5'd23) begin
              cur     <= cur << 1;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd22 && more) begin
                pix_rd   <= 1'b1;
                pix_addr <= pix_idx + AW'(1);
              end
            end else if (more) begin
              cur     <= next_word << 1;
              bit_cnt <= '0;
              pix_idx <= pix_idx + AW'(1);
            end else begin
              state <= LATCH;
              lcnt  <= '0;
            end
          end
        end
        LATCH: begin
          if (lcnt == LCW'(LATCH_CYC - 1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            lcnt <= lcnt + LCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  led_bit_encoder #(
    .T0H (T0H),
    .T1H (T1H),
    .TBIT(TBIT)
  ) u_bit_encoder (
    .clk    (clk),
    .reset  (reset),
    .bit_val(enc_bit),
    .go     (enc_go),
    .line   (to_light),
    .bit_end(bit_end)
  );

endmodule

// File: tb/tb_led_frame_driver.sv
// tb/tb_led_frame_driver.sv - scoreboard bench: decodes the serial line and checks bytes, reads and frame timing
module tb_led_frame_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel;
  logic        mon_clear;
  logic        start0, start1;
  logic        busy0, done0, rd0, tl0;
  logic        busy1, done1, rd1, tl1;
  logic [1:0]  addr0;
  logic [0:0]  addr1;
  logic [23:0] data0, data1;
  logic [23:0] mem0 [0:3];
  logic [23:0] mem1 [0:1];
`ifdef LED_BRIGHTNESS_EN
  logic [7:0]  bright0, bright1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  int         exp_addr[$];

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  logic       busy_m, done_m, rd_m, tl_m;
  logic [1:0] addr_m;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign rd_m   = sel ? rd1 : rd0;
  assign tl_m   = sel ? tl1 : tl0;
  assign addr_m = sel ? {1'b0, addr1} : addr0;

  led_frame_driver #(.NUM_LEDS(3)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .pix_rd(rd0), .pix_addr(addr0), .pix_data(data0), .to_light(tl0)
`ifdef LED_BRIGHTNESS_EN
    , .brightness(bright0)
`endif
  );

  led_frame_driver #(.NUM_LEDS(1), .ORDER(led_pkg::RGB)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .pix_rd(rd1), .pix_addr(addr1), .pix_data(data1), .to_light(tl1)
`ifdef LED_BRIGHTNESS_EN
    , .brightness(bright1)
`endif
  );

  always @(posedge clk) begin
    if (rd0) data0 <= mem0[addr0];
    if (rd1) data1 <= mem1[addr1];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line decoder and read monitor.
  int         hi = 0, lo = 1000, last_hi = 0, nb = 0;
  logic       prev = 1'b0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    if (rd_m) begin
      if (exp_addr.size() == 0) check("extra_pix_rd", addr_m, 99);
      else check("pix_addr", addr_m, exp_addr.pop_front());
    end
    if (mon_clear) begin
      hi = 0; lo = 1000; nb = 0;
    end else if (tl_m) begin
      if (!prev && lo < 500) check("bit_period", last_hi + lo, 30);
      hi++;
    end else begin
      if (prev) begin
        if (hi != 19 && hi != 10) check("bit_high_len", hi, 10);
        sh = {sh[6:0], (hi == 19)};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_bytes.size() == 0) check("extra_byte", sh, 9'h100);
          else check("wire_byte", sh, exp_bytes.pop_front());
        end
        last_hi = hi; hi = 0; lo = 0;
      end
      lo++;
    end
    prev = tl_m;
  end

  task automatic wait_done(input int exp_j, input int j0);
    int j;
    j = j0;
    while (done_m !== 1'b1 && j < exp_j + 50) begin
      @(posedge clk); #1; j++;
    end
    check("frame_len", j, exp_j);
    check("busy_at_done", busy_m, 0);
  endtask

  task automatic run_frame(input int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef LED_BRIGHTNESS_EN
    bright0 = 8'd255;
`endif
    check("fetch_busy", busy_m, 1);
    check("fetch_rd", rd_m, 1);
    wait_done(3 + n * 720 + 1920, 1);
    check("bytes_left", exp_bytes.size(), 0);
    check("reads_left", exp_addr.size(), 0);
  endtask

  task automatic push_word(input logic [23:0] w);
    exp_bytes.push_back(w[23:16]);
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[7:0]);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; sel = 1'b0; mon_clear = 1'b0;
    data0 = '0; data1 = '0;
`ifdef LED_BRIGHTNESS_EN
    bright0 = 8'd255; bright1 = 8'd255;
`endif
    mem0[0] = 24'hFF0000; mem0[1] = 24'h00FF00; mem0[2] = 24'h0000AA; mem0[3] = 24'h0;
    mem1[0] = 24'h123456; mem1[1] = 24'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_rd0", rd0, 0);
    check("rst_addr0", addr0, 0);
    check("rst_line0", tl0, 0);
    check("rst_busy1", busy1, 0);
    check("rst_line1", tl1, 0);

    start = 1'b1;
    @(posedge clk); #1;
    check("rst_over_start_busy", busy0, 0);
    check("rst_over_start_rd", rd0, 0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // Three-pixel frame, GRB memory.
    for (int i = 0; i < 3; i++) begin push_word(mem0[i]); exp_addr.push_back(i); end
    run_frame(3);
    check("addr_hold", addr0, 2);

    // Start held through a whole frame: exactly one frame, restart right after done.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 3; i++) begin push_word(mem0[i]); exp_addr.push_back(i); end
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(4083, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", busy_m, 1);
    check("restart_rd", rd_m, 1);
    check("restart_addr", addr_m, 0);
    wait_done(4083, 1);
    check("bytes_left2", exp_bytes.size(), 0);
    check("reads_left2", exp_addr.size(), 0);

    // Reset in the first cycle of bit 30 (pixel 1).
    push_word(mem0[0]);
    exp_addr.push_back(0);
    exp_addr.push_back(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (902) begin @(posedge clk); #1; end
    check("abort_line_high", tl0, 1);
    reset = 1'b1; mon_clear = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_line_low", tl0, 0);
    check("abort_busy", busy0, 0);
    ndone = 0;
    repeat (2500) begin
      if (done0) ndone++;
      @(posedge clk); #1;
    end
    mon_clear = 1'b0;
    check("abort_no_done", ndone, 0);
    check("abort_bytes_left", exp_bytes.size(), 0);
    check("abort_reads_left", exp_addr.size(), 0);

    // Single-LED RGB instance.
    sel = 1'b1;
    @(posedge clk); #1;
    exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h56);
    exp_addr.push_back(0);
    run_frame(1);
    sel = 1'b0;
    @(posedge clk); #1;

`ifdef LED_BRIGHTNESS_EN
    for (int i = 0; i < 3; i++) mem0[i] = 24'hFF8001;
    bright0 = 8'd127;
    for (int i = 0; i < 3; i++) begin push_word(24'h7F4000); exp_addr.push_back(i); end
    run_frame(3);
    for (int i = 0; i < 3; i++) begin push_word(24'hFF8001); exp_addr.push_back(i); end
    run_frame(3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
